// File: rtl/mvu_mem_port_arbiter_if.sv
// Requester-side bus bundle for mvu_mem_port_arbiter: flattened per-port request fields
// plus per-port grant/response lines and the shared response data.
interface mvu_mem_port_arbiter_if #(
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic [NumPorts-1:0]             req;
    logic [NumPorts-1:0]             we;
    logic [NumPorts*AddrWidth-1:0]   addr;
    logic [NumPorts*DataWidth/8-1:0] be;
    logic [NumPorts*DataWidth-1:0]   wdata;
    logic [NumPorts-1:0]             gnt;
    logic [NumPorts-1:0]             rvalid;
    logic [DataWidth-1:0]            rdata;
    logic [NumPorts-1:0]             err;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/mvu_mem_port_arbiter.sv
// Round-robin N-port arbiter onto one SRAM bank with latency-matched response routing.
// Optional address range check is enabled by defining MVU_MEM_ARB_RANGE_CHECK_EN.
module mvu_mem_port_arbiter #(
    parameter int unsigned          NumPorts     = 4,
    parameter int unsigned          AddrWidth    = 32,
    parameter int unsigned          DataWidth    = 32,
    parameter int unsigned          MemAddrWidth = 11,
    parameter int unsigned          ReadLatency  = 1,
    parameter logic [AddrWidth-1:0] BaseAddr     = 32'h0020_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    mvu_mem_port_arbiter_if.slave   bus,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic                    mem_we_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [DataWidth/8-1:0]  mem_be_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    input  logic [DataWidth-1:0]    mem_rdata_i,
    output logic                    busy_o
);
    localparam int unsigned BeWidth   = DataWidth / 8;
    localparam int unsigned PtrWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned ByteShift = $clog2(BeWidth);
    localparam int unsigned OutStage  = ReadLatency - 1;

    if (ReadLatency < 1) begin : gen_latency_check
        $error("mvu_mem_port_arbiter: ReadLatency must be >= 1");
    end

    typedef logic [PtrWidth-1:0] ptr_t;

    ptr_t                   ptr_q, ptr_d, sel_idx;
    logic                   gnt_any, sel_we, sel_err;
    logic [NumPorts-1:0]    gnt_vec;
    logic [AddrWidth-1:0]   sel_addr, sel_off;
    logic [BeWidth-1:0]     sel_be;
    logic [DataWidth-1:0]   sel_wdata;
    logic [ReadLatency-1:0] vld_q, vld_d, wr_q, wr_d, err_q, err_d;
    ptr_t [ReadLatency-1:0] idx_q, idx_d;
    logic                   out_vld, out_wr, out_err;
    ptr_t                   out_idx;

    function automatic ptr_t rr_idx(ptr_t base, int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NumPorts) sum = sum - NumPorts;
        return ptr_t'(sum);
    endfunction

    always_comb begin : arbitrate
        ptr_t cand;
        cand    = '0;
        gnt_any = 1'b0;
        sel_idx = ptr_q;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = rr_idx(ptr_q, i);
            if (!gnt_any && bus.req[cand]) begin
                gnt_any = 1'b1;
                sel_idx = cand;
            end
        end
        // SRAM backpressure and reset both suppress any grant this cycle.
        if (!mem_gnt_i || rst_i) gnt_any = 1'b0;
    end

    assign gnt_vec = gnt_any ? (NumPorts'(1) << sel_idx) : '0;
    assign bus.gnt = gnt_vec;

    always_comb begin : select_fields
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (gnt_vec[p]) begin
                sel_we    = bus.we[p];
                sel_addr  = bus.addr[p*AddrWidth +: AddrWidth];
                sel_be    = bus.be[p*BeWidth +: BeWidth];
                sel_wdata = bus.wdata[p*DataWidth +: DataWidth];
            end
        end
    end

    assign sel_off = sel_addr - BaseAddr;

`ifdef MVU_MEM_ARB_RANGE_CHECK_EN
    localparam longint unsigned Span = longint'(BeWidth) << MemAddrWidth;
    assign sel_err = gnt_any && ((sel_addr < BaseAddr) || (64'(sel_off) >= Span));
`else
    assign sel_err = 1'b0;
`endif

    assign mem_req_o   = gnt_any && !sel_err;
    assign mem_we_o    = sel_we;
    assign mem_addr_o  = MemAddrWidth'(sel_off >> ByteShift);
    assign mem_be_o    = sel_be;
    assign mem_wdata_o = sel_wdata;

    assign ptr_d = !gnt_any ? ptr_q :
                   (sel_idx == ptr_t'(NumPorts - 1)) ? '0 : ptr_t'(sel_idx + 1'b1);

    // Stage 0 captures the grant; stage ReadLatency-1 lines up with mem_rdata_i.
    always_comb begin : pipe_next
        vld_d    = '0;
        wr_d     = '0;
        err_d    = '0;
        idx_d    = '0;
        vld_d[0] = gnt_any;
        wr_d[0]  = sel_we;
        err_d[0] = sel_err;
        idx_d[0] = sel_idx;
        for (int unsigned k = 1; k < ReadLatency; k++) begin
            vld_d[k] = vld_q[k-1];
            wr_d[k]  = wr_q[k-1];
            err_d[k] = err_q[k-1];
            idx_d[k] = idx_q[k-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            vld_q <= '0;
            wr_q  <= '0;
            err_q <= '0;
            idx_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            wr_q  <= wr_d;
            err_q <= err_d;
            idx_q <= idx_d;
        end
    end

    assign out_vld = vld_q[OutStage];
    assign out_wr  = wr_q[OutStage];
    assign out_err = err_q[OutStage];
    assign out_idx = idx_q[OutStage];

    assign bus.rvalid = out_vld ? (NumPorts'(1) << out_idx) : '0;
    assign bus.err    = (out_vld && out_err) ? (NumPorts'(1) << out_idx) : '0;
    assign bus.rdata  = (out_vld && !out_err && !out_wr) ? mem_rdata_i : '0;
    assign busy_o     = |vld_q;
endmodule

// File: tb/tb_mvu_mem_port_arbiter.sv
// Bench for mvu_mem_port_arbiter: two instances (ReadLatency 1 and 3) share one directed
// stimulus; a queue-based model checks every cycle, plus literal spot checks.
module tb_mvu_mem_port_arbiter;
    localparam int unsigned NP   = 4;
    localparam logic [31:0] Base = 32'h0020_0000;
`ifdef MVU_MEM_ARB_RANGE_CHECK_EN
    localparam bit RangeEn = 1'b1;
`else
    localparam bit RangeEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_gnt = 1'b1;
    logic [3:0]   req = '0;
    logic [3:0]   we = '0;
    logic [127:0] addr = '0;
    logic [15:0]  be = '0;
    logic [127:0] wdata = '0;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [3:0]  gnt_w[2];
    logic [3:0]  rvalid_w[2];
    logic [3:0]  err_w[2];
    logic [31:0] rdata_w[2];
    logic        busy_w[2];
    logic        mreq_w[2];
    logic        mwe_w[2];
    logic [10:0] maddr_w[2];

    typedef struct {
        int unsigned due;
        int unsigned port;
        bit          wr;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(int unsigned i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int unsigned Lat = (g == 0) ? 1 : 3;

        mvu_mem_port_arbiter_if #(.NumPorts(NP), .AddrWidth(32), .DataWidth(32)) bus ();

        logic        mem_req, mem_we, busy;
        logic [10:0] mem_addr;
        logic [3:0]  mem_be;
        logic [31:0] mem_wdata, mem_rdata;

        assign bus.req   = req;
        assign bus.we    = we;
        assign bus.addr  = addr;
        assign bus.be    = be;
        assign bus.wdata = wdata;

        assign gnt_w[g]    = bus.gnt;
        assign rvalid_w[g] = bus.rvalid;
        assign err_w[g]    = bus.err;
        assign rdata_w[g]  = bus.rdata;
        assign busy_w[g]   = busy;
        assign mreq_w[g]   = mem_req;
        assign mwe_w[g]    = mem_we;
        assign maddr_w[g]  = mem_addr;

        mvu_mem_port_arbiter #(
            .NumPorts(NP), .AddrWidth(32), .DataWidth(32), .MemAddrWidth(11),
            .ReadLatency(Lat), .BaseAddr(Base)
        ) dut (
            .clk_i(clk), .rst_i(rst), .bus(bus),
            .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
            .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
            .mem_rdata_i(mem_rdata), .busy_o(busy)
        );

        // SRAM stub: unwritten words read as init_word(addr); garbage when no read issued.
        logic [31:0] sram[2048];
        bit          sflag[2048];
        logic [31:0] rd_pipe[Lat];

        always @(posedge clk) begin : stub
            logic [31:0] cur;
            cur = sflag[mem_addr] ? sram[mem_addr] : init_word(32'(mem_addr));
            if (mem_req && mem_we) begin
                for (int b = 0; b < 4; b++) if (mem_be[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
                sram[mem_addr]  <= cur;
                sflag[mem_addr] <= 1'b1;
            end
            rd_pipe[0] <= (mem_req && !mem_we) ? cur : 32'hDEAD_BEEF;
            for (int k = 1; k < Lat; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign mem_rdata = rd_pipe[Lat-1];

        // Behavioural model: rr pointer, word memory and a queue of due responses.
        rsp_t        q[$];
        int unsigned cyc = 0;
        int unsigned mptr = 0;
        logic [31:0] mmem[2048];
        bit          mflag[2048];

        always @(negedge clk) begin : model
            int          gp;
            int unsigned wi;
            logic [31:0] a, cur;
            bit          oor;
            rsp_t        r;
            string       tag;
            tag = $sformatf("L%0d", Lat);
            gp  = -1;
            if (rst) begin
                chk({tag, " rst gnt"}, 64'(bus.gnt), 64'd0);
                chk({tag, " rst mem_req"}, 64'(mem_req), 64'd0);
                chk({tag, " rst rvalid"}, 64'(bus.rvalid), 64'd0);
                chk({tag, " rst err"}, 64'(bus.err), 64'd0);
                chk({tag, " rst rdata"}, 64'(bus.rdata), 64'd0);
                chk({tag, " rst busy"}, 64'(busy), 64'd0);
                q.delete();
                mptr = 0;
            end else begin
                if (mem_gnt) begin
                    for (int k = 0; k < NP; k++) begin
                        if (gp < 0 && req[(mptr + k) % NP]) gp = int'((mptr + k) % NP);
                    end
                end
                chk({tag, " gnt"}, 64'(bus.gnt), (gp < 0) ? 64'd0 : (64'd1 << gp));
                chk({tag, " busy"}, 64'(busy), 64'(q.size() != 0));
                if (q.size() != 0 && q[0].due == cyc) begin
                    r = q.pop_front();
                    chk({tag, " rvalid"}, 64'(bus.rvalid), 64'd1 << r.port);
                    chk({tag, " err"}, 64'(bus.err), r.err ? (64'd1 << r.port) : 64'd0);
                    chk({tag, " rdata"}, 64'(bus.rdata), (r.wr || r.err) ? 64'd0 : 64'(r.data));
                end else begin
                    chk({tag, " rvalid idle"}, 64'(bus.rvalid), 64'd0);
                    chk({tag, " err idle"}, 64'(bus.err), 64'd0);
                    chk({tag, " rdata idle"}, 64'(bus.rdata), 64'd0);
                end
                if (gp >= 0) begin
                    a   = addr[gp*32 +: 32];
                    wi  = ((a - Base) >> 2) & 32'h7FF;
                    oor = RangeEn && ((a < Base) || ((a - Base) >= 32'd8192));
                    chk({tag, " mem_req"}, 64'(mem_req), 64'(!oor));
                    if (!oor) begin
                        chk({tag, " mem fields"}, 64'({mem_we, mem_addr, mem_be, mem_wdata}),
                            64'({we[gp], 11'(wi), be[gp*4 +: 4], wdata[gp*32 +: 32]}));
                    end
                    cur = mflag[wi] ? mmem[wi] : init_word(wi);
                    if (we[gp] && !oor) begin
                        for (int b = 0; b < 4; b++)
                            if (be[gp*4 + b]) cur[b*8 +: 8] = wdata[gp*32 + b*8 +: 8];
                        mmem[wi]  = cur;
                        mflag[wi] = 1'b1;
                    end
                    r.due  = cyc + Lat;
                    r.port = gp;
                    r.wr   = we[gp];
                    r.err  = oor;
                    r.data = cur;
                    q.push_back(r);
                    mptr = (gp + 1) % NP;
                end else begin
                    chk({tag, " mem_req idle"}, 64'(mem_req), 64'd0);
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d);
        we[p]           = w;
        addr[p*32 +: 32] = a;
        be[p*4 +: 4]    = b;
        wdata[p*32 +: 32] = d;
    endtask

    initial begin
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset rvalid %0d", g), 64'(rvalid_w[g]), 64'd0);
            chk($sformatf("reset busy %0d", g), 64'(busy_w[g]), 64'd0);
            chk($sformatf("reset rdata %0d", g), 64'(rdata_w[g]), 64'd0);
        end
        step();
        rst = 1'b0;

        // Single read from port 0 at BaseAddr+8.
        step();
        set_port(0, 1'b0, Base + 32'h8, 4'hF, 32'h0);
        req = 4'b0001;
        @(negedge clk);
        chk("t1 gnt", 64'(gnt_w[0]), 64'h1);
        chk("t1 mem_req", 64'(mreq_w[0]), 64'h1);
        chk("t1 mem_addr", 64'(maddr_w[0]), 64'h2);
        step();
        req = 4'b0000;
        @(negedge clk);
        chk("t1 rvalid", 64'(rvalid_w[0]), 64'h1);
        chk("t1 rdata", 64'(rdata_w[0]), 64'hC0DE_0002);

        // Port 3 alone moves the pointer back to 0, then all four request for 8 cycles.
        step();
        set_port(3, 1'b0, Base + 32'd80, 4'hF, 32'h0);
        req = 4'b1000;
        step();
        for (int p = 0; p < 4; p++) set_port(p, 1'b0, Base + 32'(4 * (16 + p)), 4'hF, 32'(p));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rr L1 %0d", k), 64'(gnt_w[0]), 64'd1 << (k % 4));
            chk($sformatf("rr L3 %0d", k), 64'(gnt_w[1]), 64'd1 << (k % 4));
            step();
        end

        // SRAM stall with ports 0 and 2 waiting.
        req = 4'b0101;
        mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall gnt %0d", k), 64'(gnt_w[0]), 64'h0);
            chk($sformatf("stall mem_req %0d", k), 64'(mreq_w[0]), 64'h0);
            step();
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        chk("unstall gnt L1", 64'(gnt_w[0]), 64'h1);
        chk("unstall gnt L3", 64'(gnt_w[1]), 64'h1);
        step();
        @(negedge clk);
        chk("unstall next gnt", 64'(gnt_w[0]), 64'h4);
        step();
        req = 4'b0000;
        repeat (3) step();

        // Port 1 writes word 5 with be=0101, then reads it back (latency 3 instance).
        set_port(1, 1'b1, Base + 32'd20, 4'b0101, 32'h1122_3344);
        req = 4'b0010;
        @(negedge clk);
        chk("wr gnt", 64'(gnt_w[1]), 64'h2);
        chk("wr mem_we", 64'(mwe_w[1]), 64'h1);
        step();
        we[1] = 1'b0;
        @(negedge clk);
        chk("rd gnt", 64'(gnt_w[1]), 64'h2);
        step();
        req = 4'b0000;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("wr rvalid +3", 64'(rvalid_w[1]), 64'h2);
        chk("wr rdata +3", 64'(rdata_w[1]), 64'h0);
        step();
        @(negedge clk);
        chk("rd rvalid +4", 64'(rvalid_w[1]), 64'h2);
        chk("rd rdata +4", 64'(rdata_w[1]), 64'hC022_0044);
        step();

        // Read below BaseAddr from port 2, then past the top of the bank from port 0.
        set_port(2, 1'b0, Base - 32'd4, 4'hF, 32'h0);
        req = 4'b0100;
        @(negedge clk);
        chk("low gnt", 64'(gnt_w[0]), 64'h4);
`ifdef MVU_MEM_ARB_RANGE_CHECK_EN
        chk("low mem_req", 64'(mreq_w[0]), 64'h0);
`else
        chk("low mem_addr wrap", 64'(maddr_w[0]), 64'h7FF);
`endif
        step();
        set_port(0, 1'b0, Base + 32'd8192 + 32'd12, 4'hF, 32'h0);
        req = 4'b0001;
        @(negedge clk);
`ifdef MVU_MEM_ARB_RANGE_CHECK_EN
        chk("low err", 64'(err_w[0]), 64'h4);
        chk("low rdata", 64'(rdata_w[0]), 64'h0);
`else
        chk("low rvalid", 64'(rvalid_w[0]), 64'h4);
        chk("low rdata wrap", 64'(rdata_w[0]), 64'hC0DE_07FF);
`endif
        step();
        req = 4'b0000;
        repeat (4) step();

        // Reset with two responses in flight on the latency-3 instance.
        set_port(0, 1'b0, Base + 32'd120, 4'hF, 32'h0);
        set_port(2, 1'b0, Base + 32'd124, 4'hF, 32'h0);
        req = 4'b0101;
        step();
        step();
        req = 4'b0000;
        #1 rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst pulse rvalid %0d", g), 64'(rvalid_w[g]), 64'h0);
            chk($sformatf("rst pulse busy %0d", g), 64'(busy_w[g]), 64'h0);
            chk($sformatf("rst pulse gnt %0d", g), 64'(gnt_w[g]), 64'h0);
        end
        #2 rst = 1'b0;
        repeat (4) begin
            step();
            @(negedge clk);
            chk("post rst rvalid L1", 64'(rvalid_w[0]), 64'h0);
            chk("post rst rvalid L3", 64'(rvalid_w[1]), 64'h0);
        end
        step();
        req = 4'b1111;
        @(negedge clk);
        chk("post rst ptr L1", 64'(gnt_w[0]), 64'h1);
        chk("post rst ptr L3", 64'(gnt_w[1]), 64'h1);
        step();
        req = 4'b0000;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
